// File: rtl/mem_pkg.sv
// Shared definitions for the multi-cycle data memory: RV32 load/store funct3
// codes, the controller state encoding and the byte-enable helper.
// Latency: n/a (package). Backpressure: n/a.
package mem_pkg;

  // RV32 funct3 encodings for loads/stores
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // Byte enables for a store of the given size at byte lane 'lane'.
  // size[2] (unsigned flag) does not affect which lanes are touched.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // 011, 110 and 111 have no load/store meaning
  function automatic logic size_illegal(input logic [2:0] size);
    return (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: picks the byte/halfword lane out of a stored word and
// sign- or zero-extends it according to funct3.
// Latency: combinational. Backpressure: none.
// Ports: i_word (raw stored word), i_size (funct3), i_lane (addr[1:0]),
//        o_data (extended load value).
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    case (i_size)
      MEM_B:   o_data = {{24{w_byte[7]}}, w_byte};
      MEM_BU:  o_data = {24'd0, w_byte};
      MEM_H:   o_data = {{16{w_half[15]}}, w_half};
      MEM_HU:  o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_memory_mc.sv
// Multi-cycle byte-addressed data memory with RV32 sized loads/stores,
// configurable wait states and error detection.
// Latency: Mem_Ready pulses WAIT_STATES+2 cycles after the accepting edge.
// Backpressure: requester holds Mem_Read/Mem_Write until Mem_Ready; one
// outstanding request, one bubble cycle between back-to-back requests.
// Ports: clk, rst (async active-low), Mem_Read/Mem_Write (request),
//        Mem_Size (funct3), Read_addr (byte address), Write_Data,
//        Mem_data_out (load result), Mem_Ready (done pulse), Mem_Error.
module data_memory_mc
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic [2:0]            Mem_Size,
  input  logic [ADDR_WIDTH-1:0] Read_addr,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic [DATA_WIDTH-1:0] Mem_data_out,
  output logic                  Mem_Ready,
  output logic                  Mem_Error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  mem_state_t            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_size;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_err;

  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_lane;
  logic [3:0]            w_be;
  logic [31:0]           w_wlanes;
  logic [31:0]           w_load;
  logic                  w_misalign;
  logic                  w_range;
  logic                  w_err;

  assign w_idx  = r_addr[IDX_W+1:2];
  assign w_lane = r_addr[1:0];
  assign w_be   = byte_en(r_size, w_lane);

  // Replicate store data across lanes so byte enables alone pick the target
  always_comb begin
    case (r_size[1:0])
      2'b00:   w_wlanes = {4{r_wdata[7:0]}};
      2'b01:   w_wlanes = {2{r_wdata[15:0]}};
      default: w_wlanes = r_wdata;
    endcase
  end

  assign w_misalign = ((r_size[1:0] == 2'b01) && w_lane[0]) ||
                      ((r_size[1:0] == 2'b10) && (w_lane != 2'b00));
  // Any address bit above the word index means addr >= DEPTH*4
  assign w_range    = |(r_addr >> (IDX_W + 2));
  assign w_err      = w_misalign || w_range || size_illegal(r_size) || (r_rd && r_wr);

  mem_load_align u_align (
    .i_word (r_mem[w_idx]),
    .i_size (r_size),
    .i_lane (w_lane),
    .o_data (w_load)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_err        <= 1'b0;
      Mem_data_out <= '0;
      Mem_Ready    <= 1'b0;
      Mem_Error    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          Mem_Ready <= 1'b0;
          Mem_Error <= 1'b0;
          // A request still high during the completion cycle belongs to the
          // transaction just finished, so it is not re-accepted.
          if ((Mem_Read || Mem_Write) && !Mem_Ready) begin
            r_addr  <= Read_addr;
            r_wdata <= Write_Data;
            r_size  <= Mem_Size;
            r_rd    <= Mem_Read;
            r_wr    <= Mem_Write;
            if (WAIT_STATES > 0) begin
              r_cnt   <= CNT_INIT;
              r_state <= WAIT;
            end else begin
              r_state <= EXEC;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= EXEC;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        EXEC: begin
          r_err <= w_err;
          if (w_err) begin
            Mem_data_out <= '0;
          end else if (r_wr) begin
            for (int b = 0; b < 4; b++)
              if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
          end else begin
            Mem_data_out <= w_load;
          end
          r_state <= DONE;
        end
        default: begin
          // DONE: raise the completion pulse for one cycle
          Mem_Ready <= 1'b1;
          Mem_Error <= r_err;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_mc.sv
module tb_data_memory_mc;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd [3];
  logic        wr [3];
  logic [2:0]  sz [3];
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic [31:0] dout [3];
  logic        rdy [3];
  logic        err [3];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          done_cyc [3];
  int          nissue [3];
  int          nrdy [3];
  exp_t        q0[$], q1[$], q2[$];
  logic [7:0]  mdl [3][256];
  logic [31:0] last_out [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_mc #(.WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst), .Mem_Read(rd[0]), .Mem_Write(wr[0]), .Mem_Size(sz[0]),
    .Read_addr(ad[0]), .Write_Data(wd[0]), .Mem_data_out(dout[0]), .Mem_Ready(rdy[0]), .Mem_Error(err[0]));
  data_memory_mc #(.WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .Mem_Read(rd[1]), .Mem_Write(wr[1]), .Mem_Size(sz[1]),
    .Read_addr(ad[1]), .Write_Data(wd[1]), .Mem_data_out(dout[1]), .Mem_Ready(rdy[1]), .Mem_Error(err[1]));
  data_memory_mc #(.WAIT_STATES(3)) u2 (
    .clk(clk), .rst(rst), .Mem_Read(rd[2]), .Mem_Write(wr[2]), .Mem_Size(sz[2]),
    .Read_addr(ad[2]), .Write_Data(wd[2]), .Mem_data_out(dout[2]), .Mem_Ready(rdy[2]), .Mem_Error(err[2]));

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  function automatic int nbytes(input logic [2:0] s);
    return (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic r, input logic w, input logic [2:0] s, input logic [31:0] a);
    if (r && w) return 1'b1;
    if (s == 3'b011 || s == 3'b110 || s == 3'b111) return 1'b1;
    if ((a % nbytes(s)) != 0) return 1'b1;
    return a >= 32'd256;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic clear_models();
    for (int k = 0; k < 3; k++) begin
      last_out[k] = 32'd0;
      done_cyc[k] = -10;
      for (int i = 0; i < 256; i++) mdl[k][i] = 8'd0;
    end
  endtask

  task automatic push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Monitor: each completion pulse pops one expectation and compares.
  task automatic mon(input int k);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    nrdy[k]++;
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready inst%0d: got Mem_Ready with no request pending (cycle %0d)", k, cyc);
      return;
    end
    chk($sformatf("data_out inst%0d", k), dout[k], e.data);
    chk($sformatf("error inst%0d", k), {31'd0, err[k]}, {31'd0, e.err});
    chk($sformatf("ready_cycle inst%0d", k), cyc, e.due);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1)
      for (int k = 0; k < 3; k++)
        if (rdy[k]) mon(k);
  end

  // Issue one request, record expectation from the byte-level model, hold
  // the request until completion (bounded).
  task automatic op(input int k, input logic r, input logic w, input logic [2:0] s,
                    input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] v;
    int          nb;
    int          acc;
    bit          got;
    nb    = nbytes(s);
    e.err = model_err(r, w, s, a);
    if (e.err) begin
      last_out[k] = 32'd0;
    end else if (w) begin
      for (int i = 0; i < nb; i++) mdl[k][a + i] = d[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(mdl[k][a + i]) << (8 * i));
      if (!s[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
      if (!s[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
      last_out[k] = v;
    end
    e.data = last_out[k];
    // Issued in the same cycle a completion is visible: accepted one edge later
    acc   = (cyc == done_cyc[k]) ? 2 : 1;
    e.due = cyc + acc + ws_of(k) + 2;
    push(k, e);
    nissue[k]++;
    rd[k] = r; wr[k] = w; sz[k] = s; ad[k] = a; wd[k] = d;
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (rdy[k]) begin got = 1'b1; break; end
    end
    rd[k] = 1'b0; wr[k] = 1'b0;
    done_cyc[k] = cyc;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout inst%0d: got no Mem_Ready, expected one within 40 cycles", k);
    end
  endtask

  initial begin
    logic [2:0] s;
    logic [31:0] a;
    int sel;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; sz[k] = 3'd0; ad[k] = 32'd0; wd[k] = 32'd0;
      nissue[k] = 0; nrdy[k] = 0;
    end
    clear_models();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset data_out inst%0d", k), dout[k], 32'd0);
      chk($sformatf("reset ready inst%0d", k), {31'd0, rdy[k]}, 32'd0);
      chk($sformatf("reset error inst%0d", k), {31'd0, err[k]}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Basic store/load
    op(0, 0, 1, MEM_W, 32'h28, 32'h64);
    op(0, 1, 0, MEM_W, 32'h28, 32'h0);
    chk("lw 0x28", dout[0], 32'h64);
    // Byte store into a word, signed/unsigned byte loads
    op(0, 0, 1, MEM_W, 32'h40, 32'h11223344);
    op(0, 0, 1, MEM_B, 32'h41, 32'hAB);
    op(0, 1, 0, MEM_W, 32'h40, 32'h0);
    chk("lw 0x40", dout[0], 32'h1122AB44);
    op(0, 1, 0, MEM_B, 32'h41, 32'h0);
    chk("lb 0x41", dout[0], 32'hFFFFFFAB);
    op(0, 1, 0, MEM_BU, 32'h41, 32'h0);
    chk("lbu 0x41", dout[0], 32'h000000AB);
    // Halfwords
    op(0, 0, 1, MEM_H, 32'h50, 32'h8001);
    op(0, 1, 0, MEM_H, 32'h50, 32'h0);
    chk("lh 0x50", dout[0], 32'hFFFF8001);
    op(0, 1, 0, MEM_HU, 32'h50, 32'h0);
    chk("lhu 0x50", dout[0], 32'h00008001);
    op(0, 0, 1, MEM_H, 32'h52, 32'h7FFF);
    op(0, 1, 0, MEM_W, 32'h50, 32'h0);
    chk("lw 0x50", dout[0], 32'h7FFF8001);
    // Errors: misaligned, out of range, read+write, illegal size
    op(0, 1, 0, MEM_W, 32'h2A, 32'h0);
    chk("misaligned err", {31'd0, err[0]}, 32'd1);
    chk("misaligned data", dout[0], 32'd0);
    op(0, 0, 1, MEM_W, 32'h100, 32'h5555);
    chk("range err", {31'd0, err[0]}, 32'd1);
    op(0, 1, 1, MEM_W, 32'h28, 32'h0);
    chk("rd+wr err", {31'd0, err[0]}, 32'd1);
    op(0, 1, 0, 3'b011, 32'h28, 32'h0);
    op(0, 1, 0, MEM_W, 32'h28, 32'h0);
    chk("lw 0x28 after errors", dout[0], 32'h64);

    // Reset during WAIT of a store aborts it
    @(negedge clk);
    wr[0] = 1'b1; sz[0] = MEM_W; ad[0] = 32'h44; wd[0] = 32'hDEADBEEF;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort data_out", dout[0], 32'd0);
    chk("abort ready", {31'd0, rdy[0]}, 32'd0);
    wr[0] = 1'b0;
    clear_models();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    op(0, 1, 0, MEM_W, 32'h44, 32'h0);
    chk("lw 0x44 after abort", dout[0], 32'd0);

    // Wait-state sweep: back-to-back requests on the 0- and 3-wait instances
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 4; i++) op(k, 0, 1, MEM_W, 32'(i * 4), 32'(32'hA0 + i));
      for (int i = 0; i < 4; i++) op(k, 1, 0, MEM_W, 32'(i * 4), 32'h0);
    end

    // Randomised traffic on the 1-wait instance
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) s = 3'b011;
      else if (sel < 3) s = MEM_B;
      else if (sel < 5) s = MEM_H;
      else if (sel < 8) s = MEM_W;
      else if (sel == 8) s = MEM_BU;
      else s = MEM_HU;
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(s)) - 32'd1);
      if ($urandom_range(0, 15) == 0) a = 32'($urandom_range(256, 400));
      if ($urandom_range(0, 1) == 1) begin
        if (s[2]) s = {1'b0, s[1:0]};
        op(0, ($urandom_range(0, 15) == 0), 1, s, a, $urandom);
      end else begin
        op(0, 1, 0, s, a, 32'h0);
      end
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    repeat (8) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("ready count inst%0d", k), 32'(nrdy[k]), 32'(nissue[k]));
    chk("scoreboard empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
